fft_bfly_sched: RTL
===================

FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 The block SHALL have no parameters; FFT size is fixed at 16 points, data word 32 bits ({real[31:16], imag[15:0]}, signed 16-bit each).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din_valid  input  1  input sample strobe.
REQ-005 din  input  32  input sample, packed complex.
REQ-006 in_ready  output  1  high while the block accepts samples (LOAD state).
REQ-007 bf_en  output  1  high while a butterfly operation is issued.
REQ-008 bf_x  output  32  butterfly top operand.
REQ-009 bf_y  output  32  butterfly bottom operand.
REQ-010 bf_tw  output  3  twiddle index k selecting W16^k.
REQ-011 bf_a  input  32  butterfly sum result (combinational from bf_x/bf_y).
REQ-012 bf_b  input  32  butterfly difference-times-twiddle result (combinational).
REQ-013 dout_valid  output  1  output sample strobe.
REQ-014 dout  output  32  output sample, natural frequency order.
REQ-015 dout_idx  output  4  frequency index of dout.
REQ-016 done  output  1  one-cycle pulse with the last output sample.

Function
REQ-017 The block SHALL own a 16x32 in-place sample buffer and a 3-state FSM: LOAD -> CALC -> OUT -> LOAD.
REQ-018 LOAD: in_ready=1; each cycle with din_valid=1 SHALL write din to buf[wcnt] and increment wcnt (0..15); the cycle after sample 15 is accepted SHALL be the first CALC cycle, wcnt back to 0.
REQ-019 din_valid while in_ready=0 SHALL be ignored (no buffer write, no counter change).
REQ-020 CALC: 32 cycles, stage s=0..3, pair p=0..7, bf_en=1 every cycle; span=8>>s, j=p mod span, g=p/span, top=2*span*g+j, bot=top+span, bf_tw=j<<s (3 bits).
REQ-021 CALC: bf_x=buf[top], bf_y=buf[bot] combinationally; at the clock edge buf[top]<=bf_a and buf[bot]<=bf_b.
REQ-022 After stage 3 pair 7 the FSM SHALL enter OUT on the next cycle.
REQ-023 OUT: 16 cycles, n=0..15; dout_valid=1, dout_idx=n, dout=buf[bitrev4(n)] combinationally; no backpressure.
REQ-024 done SHALL be 1 only in OUT cycle n=15; the next cycle SHALL be LOAD with in_ready=1.
REQ-025 Outside CALC bf_en=0, bf_x=bf_y=0, bf_tw=0; outside OUT dout_valid=0, dout=0, dout_idx=0.
REQ-026 Latency: sample 15 accepted on edge E; CALC cycles E+1..E+32; OUT cycles E+33..E+48; done at E+48.
REQ-027 The block SHALL perform no arithmetic on data; result width/saturation is owned by the butterfly datapath.

Reset
REQ-028 rst=1 on an edge SHALL force LOAD, wcnt=0, stage/pair/out counters=0, buffer cleared to 0, regardless of current state.
REQ-029 During and after reset: in_ready=1, bf_en=0, dout_valid=0, done=0, all data outputs 0.
REQ-030 rst asserted mid-CALC or mid-OUT SHALL abandon the frame; no further bf_en or dout_valid until a full new frame of 16 samples is loaded.

Verification
REQ-031 Impulse: din[0]=0x0010_0000, din[1..15]=0, bench model butterfly -> 16 outputs all 0x0010_0000, dout_idx 0..15 in order, done with idx 15.
REQ-032 DC: all 16 samples 0x0001_0000 -> dout idx 0 = 0x0010_0000, idx 1..15 = 0x0000_0000.
REQ-033 Schedule trace: check bf_x/bf_y source indices and bf_tw: stage 0 p=3 -> top 3, bot 11, tw 3; stage 1 p=5 -> top 9, bot 13, tw 2; stage 3 p=7 -> top 14, bot 15, tw 0; exactly 32 bf_en cycles.
REQ-034 Gapped input: din_valid toggled 1/0 with 16 valid beats plus din_valid=1 pulses during CALC and OUT -> same outputs as contiguous load, ignored beats have no effect, CALC starts one cycle after 16th accepted beat.
REQ-035 Reset mid-operation: rst at CALC cycle 10 -> next cycle in_ready=1, bf_en=0; subsequent fresh impulse frame yields REQ-031 result.
REQ-036 Back-to-back frames: second frame loaded immediately after done -> in_ready high the cycle after done, second frame results correct and independent of the first.

Source files
------------

// File: rtl/fft_bfly_sched_if.sv
// Handshake and datapath bundle between the 16-point FFT scheduler and its environment.
// The scheduler is the slave; the environment drives samples and the external butterfly results.
interface fft_bfly_sched_if;
  logic        din_valid;
  logic [31:0] din;
  logic        in_ready;
  logic        bf_en;
  logic [31:0] bf_x;
  logic [31:0] bf_y;
  logic [2:0]  bf_tw;
  logic [31:0] bf_a;
  logic [31:0] bf_b;
  logic        dout_valid;
  logic [31:0] dout;
  logic [3:0]  dout_idx;
  logic        done;

  modport master (
    output din_valid, din, bf_a, bf_b,
    input  in_ready, bf_en, bf_x, bf_y, bf_tw, dout_valid, dout, dout_idx, done
  );

  modport slave (
    input  din_valid, din, bf_a, bf_b,
    output in_ready, bf_en, bf_x, bf_y, bf_tw, dout_valid, dout, dout_idx, done
  );
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIF scheduler for a 16-point FFT: loads a frame, issues 32 butterflies to an
// external datapath, then streams the results out in natural frequency order.
module fft_bfly_sched (
  input logic              clk,
  input logic              rst,
  fft_bfly_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wrCount_q, wrCount_d;
  logic [1:0]  stage_q, stage_d;
  logic [2:0]  pair_q, pair_d;
  logic [3:0]  outCount_q, outCount_d;
  logic [31:0] mem_q [16];

  logic [3:0]  topIdx;
  logic [3:0]  botIdx;
  logic [3:0]  span;
  logic [2:0]  twIdx;
  logic        loadWe;
  logic        calcWe;

  function automatic logic [3:0] bitRev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // Top index is the pair number with a zero inserted at the span bit; bottom sets that bit.
  always_comb begin
    topIdx = 4'd0;
    twIdx  = 3'd0;
    span   = 4'd8 >> stage_q;
    case (stage_q)
      2'd0: begin
        topIdx = {1'b0, pair_q};
        twIdx  = pair_q;
      end
      2'd1: begin
        topIdx = {pair_q[2], 1'b0, pair_q[1:0]};
        twIdx  = {pair_q[1:0], 1'b0};
      end
      2'd2: begin
        topIdx = {pair_q[2:1], 1'b0, pair_q[0]};
        twIdx  = {pair_q[0], 2'b00};
      end
      default: begin
        topIdx = {pair_q, 1'b0};
        twIdx  = 3'd0;
      end
    endcase
    botIdx = topIdx | span;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      wrCount_q  <= 4'd0;
      stage_q    <= 2'd0;
      pair_q     <= 3'd0;
      outCount_q <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      wrCount_q  <= wrCount_d;
      stage_q    <= stage_d;
      pair_q     <= pair_d;
      outCount_q <= outCount_d;
      if (loadWe) begin
        mem_q[wrCount_q] <= bus.din;
      end
      if (calcWe) begin
        mem_q[topIdx] <= bus.bf_a;
        mem_q[botIdx] <= bus.bf_b;
      end
    end
  end

  // Stage and pair form one 5-bit counter so the last pair of a stage rolls into the next stage.
  always_comb begin
    state_d    = state_q;
    wrCount_d  = wrCount_q;
    stage_d    = stage_q;
    pair_d     = pair_q;
    outCount_d = outCount_q;
    loadWe     = 1'b0;
    calcWe     = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.din_valid) begin
          loadWe    = 1'b1;
          wrCount_d = wrCount_q + 4'd1;
          if (wrCount_q == 4'd15) begin
            state_d = CALC;
            stage_d = 2'd0;
            pair_d  = 3'd0;
          end
        end
      end
      CALC: begin
        calcWe            = 1'b1;
        {stage_d, pair_d} = {stage_q, pair_q} + 5'd1;
        if (stage_q == 2'd3 && pair_q == 3'd7) begin
          state_d    = OUT;
          outCount_d = 4'd0;
        end
      end
      OUT: begin
        outCount_d = outCount_q + 4'd1;
        if (outCount_q == 4'd15) begin
          state_d   = LOAD;
          wrCount_d = 4'd0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == LOAD);
    bus.bf_en      = 1'b0;
    bus.bf_x       = 32'd0;
    bus.bf_y       = 32'd0;
    bus.bf_tw      = 3'd0;
    bus.dout_valid = 1'b0;
    bus.dout       = 32'd0;
    bus.dout_idx   = 4'd0;
    bus.done       = 1'b0;
    if (state_q == CALC) begin
      bus.bf_en = 1'b1;
      bus.bf_x  = mem_q[topIdx];
      bus.bf_y  = mem_q[botIdx];
      bus.bf_tw = twIdx;
    end
    if (state_q == OUT) begin
      bus.dout_valid = 1'b1;
      bus.dout       = mem_q[bitRev4(outCount_q)];
      bus.dout_idx   = outCount_q;
      bus.done       = (outCount_q == 4'd15);
    end
  end

endmodule
